fire_detector: RTL and testbench
================================

# fire_detector

Upstream stage of the extinguisher. Debounces eight zone smoke/heat sensors, picks the lowest-numbered burning zone, and drives the extinguisher `enable` request. It then tracks the extinguisher's `active` sweep, re-checks the zone afterwards, and re-arms or escalates to a fault. The `zone` output gives the supervisor the target position, matched against the extinguisher's 3-bit `position`.

## Interface
- `DEBOUNCE`, 4: consecutive high samples needed to qualify a sensor (1..15).
- `MAX_RETRY`, 3: re-arm attempts after a failed check before fault (1..7).
- `ACK_TIMEOUT`, 32: cycles allowed in REQ for `ext_active` to rise (`FIRE_DET_FAULT_EN` only).
- `clk` in 1: rising-edge clock.
- `clr` in 1: reset, synchronous and active-high; one clock, one reset.
- `sensor` in 8: raw zone sensors, bit i = zone i, already synchronised.
- `ext_active` in 1: extinguisher `active` feedback.
- `enable` out 1: extinguish request to the extinguisher.
- `zone` out 3: zone currently being serviced.
- `alarm` out 1: fire being handled, or fault.
- `fault` out 1: sticky failure flag.
- `fires_handled` out 8: count of zones successfully cleared, wraps 255→0.

## Operation
- Debounce: each zone has a 4-bit saturating counter.
  - `sensor[i]`=1 increments the counter; `sensor[i]`=0 clears it.
  - `qual[i]` = (counter ≥ DEBOUNCE), registered.
- FSM states: IDLE, REQ, SWEEP, CHECK, FAULT.
- IDLE → REQ when any `qual` bit is set.
  - `zone` latches the lowest set index.
  - `retry` is cleared.
- REQ: `enable`=1.
  - Goes to SWEEP on `ext_active`=1.
- SWEEP: `enable`=0.
  - Goes to CHECK on `ext_active`=0.
- CHECK, one cycle:
  - If `qual[zone]`=0: go to IDLE and increment `fires_handled`.
  - Otherwise, if `retry`==MAX_RETRY: go to FAULT.
  - Otherwise: `retry`++ and go to REQ.
- FAULT: `enable`=0, `fault`=1.
  - Left only by `clr`.
- `alarm`=1 in every state except IDLE.
- New qualifications in other zones while not in IDLE are ignored. They are re-evaluated on the first IDLE cycle; debounce counters keep running.
- `zone` holds its value in all states except IDLE → REQ, and keeps the last serviced zone while in IDLE.

## Timing
- Reset values: `enable`=0, `zone`=0, `alarm`=0, `fault`=0, `fires_handled`=0, all debounce counters 0, `retry`=0, state IDLE.
- `clr` asserted mid-operation returns everything to reset values at that edge, regardless of `ext_active`.
- Latency: `sensor[i]` rises at edge k and is held.
  - `qual[i]`=1 after edge k+DEBOUNCE.
  - `enable`/`alarm`/`zone` are valid one edge later.
- All outputs are registered; no combinational path from inputs to outputs.
- If `ext_active` is already 1 on REQ entry, REQ lasts exactly one cycle.
- CHECK samples `qual` in its own cycle; `enable` re-rises the cycle after CHECK on a retry.
- Simultaneous qualification of zones 2 and 5 on the same edge → zone 2 is serviced first.
- `fires_handled` increments on the CHECK → IDLE edge only, and wraps modulo 256.

## Configuration
- `FIRE_DET_FAULT_EN` defined:
  - REQ counts cycles and goes to FAULT when the count reaches ACK_TIMEOUT without `ext_active`.
  - The MAX_RETRY limit is enforced.
- Not defined:
  - No timeout; REQ waits indefinitely.
  - CHECK always re-arms on a still-qualified zone.
  - `fault` is tied to 0 and the FAULT state is unreachable.

## Structure
- Shared package holds:
  - the state encoding typedef (IDLE=0, REQ=1, SWEEP=2, CHECK=3, FAULT=4, 3-bit);
  - `ZONE_W`=3 and `NZONES`=8, shared with the extinguisher's `position` width.
- One sub-module: `zone_debounce`, with ports `clk`, `clr`, `in`, `qual` and parameter DEBOUNCE, instantiated 8× via generate.
- The FSM, priority encoder and counters live in the top level.

## Test plan
- Zone 3 high for 3 cycles then low, with DEBOUNCE=4 → `enable` never asserts, `alarm` stays 0.
- Zone 3 held high → `enable`=1 and `zone`=3 on edge 5.
  - Pulse `ext_active` high 8 cycles while dropping `sensor` → returns to IDLE, `fires_handled`=1.
- Zones 6 and 1 qualify together → zone 1 serviced first, then zone 6 re-requested after the return to IDLE.
- Zone 0 stays lit through 4 sweeps with MAX_RETRY=3 and the macro defined → `fault`=1, `alarm`=1, `enable`=0 after the 4th CHECK.
- Macro defined, `ext_active` held 0 → FAULT exactly 32 cycles after REQ entry.
  - Without the macro → still in REQ after 100 cycles.
- `clr` pulsed during SWEEP → all outputs at reset values on the next edge.
  - Re-qualification restarts from a zero debounce count.

Source files
------------

// File: rtl/fire_detector_pkg.sv
// Shared types and constants for the fire detector and the extinguisher it feeds.
// The zone width matches the extinguisher's position bus.
package fire_detector_pkg;

  localparam int ZONE_W = 3;
  localparam int NZONES = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_SWEEP = 3'd2,
    ST_CHECK = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  // Lowest-numbered set bit wins, so zone 0 has the highest priority.
  function automatic logic [ZONE_W-1:0] lowest_set(input logic [NZONES-1:0] v);
    lowest_set = '0;
    for (int i = NZONES - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = ZONE_W'(i);
    end
  endfunction

endpackage

// File: rtl/zone_debounce.sv
// Per-zone debounce: a saturating run-length counter of high samples.
// qual is registered and rises on the edge where the run reaches DEBOUNCE.
module zone_debounce #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic clr,
  input  logic in,
  output logic qual
);

  logic [3:0] cnt;
  logic [3:0] cnt_nx;

  always_comb begin
    cnt_nx = 4'd0;
    if (in) cnt_nx = (cnt == 4'hF) ? cnt : cnt + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt  <= 4'd0;
      qual <= 1'b0;
    end else begin
      cnt  <= cnt_nx;
      qual <= (cnt_nx >= 4'(DEBOUNCE));
    end
  end

endmodule

// File: rtl/fire_detector.sv
// Zone fire detector: debounce, priority pick, extinguisher handshake and re-check.
// Define FIRE_DET_FAULT_EN to enable the REQ ack timeout, the retry limit and FAULT.
module fire_detector
  import fire_detector_pkg::*;
#(
  parameter int DEBOUNCE    = 4,
  parameter int MAX_RETRY   = 3,
  parameter int ACK_TIMEOUT = 32
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [NZONES-1:0] sensor,
  input  logic              ext_active,
  output logic              enable,
  output logic [ZONE_W-1:0] zone,
  output logic              alarm,
  output logic              fault,
  output logic [7:0]        fires_handled
);

  logic [NZONES-1:0] qual;
  state_t            state, state_nx;
  logic [ZONE_W-1:0] zone_nx;
  logic [2:0]        retry, retry_nx;
  logic [7:0]        fires_nx;

  for (genvar gi = 0; gi < NZONES; gi++) begin : g_deb
    zone_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb (
      .clk  (clk),
      .clr  (clr),
      .in   (sensor[gi]),
      .qual (qual[gi])
    );
  end

`ifdef FIRE_DET_FAULT_EN
  localparam int TMR_W = $clog2(ACK_TIMEOUT) + 1;
  logic [TMR_W-1:0] tmr;
  logic             ack_timeout;

  // tmr equals the number of completed REQ cycles spent waiting for ext_active.
  always_ff @(posedge clk) begin
    if (clr || state != ST_REQ || ext_active) tmr <= '0;
    else                                      tmr <= tmr + 1'b1;
  end

  assign ack_timeout = (tmr == TMR_W'(ACK_TIMEOUT - 1));
`endif

  always_comb begin
    state_nx = state;
    zone_nx  = zone;
    retry_nx = retry;
    fires_nx = fires_handled;
    case (state)
      ST_IDLE: begin
        if (|qual) begin
          state_nx = ST_REQ;
          zone_nx  = lowest_set(qual);
          retry_nx = 3'd0;
        end
      end
      ST_REQ: begin
        if (ext_active) state_nx = ST_SWEEP;
`ifdef FIRE_DET_FAULT_EN
        else if (ack_timeout) state_nx = ST_FAULT;
`endif
      end
      ST_SWEEP: begin
        if (!ext_active) state_nx = ST_CHECK;
      end
      ST_CHECK: begin
        if (!qual[zone]) begin
          state_nx = ST_IDLE;
          fires_nx = fires_handled + 8'd1;
        end
`ifdef FIRE_DET_FAULT_EN
        else if (retry == 3'(MAX_RETRY)) begin
          state_nx = ST_FAULT;
        end
`endif
        else begin
          state_nx = ST_REQ;
          retry_nx = retry + 3'd1;
        end
      end
      ST_FAULT: state_nx = ST_FAULT;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state.
  always_ff @(posedge clk) begin
    if (clr) begin
      state         <= ST_IDLE;
      zone          <= '0;
      retry         <= 3'd0;
      fires_handled <= 8'd0;
      enable        <= 1'b0;
      alarm         <= 1'b0;
    end else begin
      state         <= state_nx;
      zone          <= zone_nx;
      retry         <= retry_nx;
      fires_handled <= fires_nx;
      enable        <= (state_nx == ST_REQ);
      alarm         <= (state_nx != ST_IDLE);
    end
  end

`ifdef FIRE_DET_FAULT_EN
  always_ff @(posedge clk) begin
    if (clr) fault <= 1'b0;
    else     fault <= (state_nx == ST_FAULT);
  end
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_fire_detector.sv
// Bench for fire_detector: directed scenarios plus randomized sensors and a
// behavioural extinguisher, all checked every cycle against a reference model.
module tb_fire_detector;
  import fire_detector_pkg::*;

  localparam int DEBOUNCE    = 4;
  localparam int MAX_RETRY   = 3;
  localparam int ACK_TIMEOUT = 32;

  localparam int P_IDLE  = 0;
  localparam int P_REQ   = 1;
  localparam int P_SWEEP = 2;
  localparam int P_CHECK = 3;
  localparam int P_FAULT = 4;

  logic              clk = 1'b0;
  logic              clr = 1'b1;
  logic [NZONES-1:0] sensor = '0;
  logic              ext_active = 1'b0;
  logic              enable;
  logic [ZONE_W-1:0] zone;
  logic              alarm;
  logic              fault;
  logic [7:0]        fires_handled;

  always #5 clk = ~clk;

  fire_detector #(
    .DEBOUNCE    (DEBOUNCE),
    .MAX_RETRY   (MAX_RETRY),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clk           (clk),
    .clr           (clr),
    .sensor        (sensor),
    .ext_active    (ext_active),
    .enable        (enable),
    .zone          (zone),
    .alarm         (alarm),
    .fault         (fault),
    .fires_handled (fires_handled)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: run lengths of high samples per zone and a phase number.
  int run [NZONES];
  int ph, mz, mr, mwait, mf;

  task automatic model_reset();
    for (int i = 0; i < NZONES; i++) run[i] = 0;
    ph = P_IDLE; mz = 0; mr = 0; mwait = 0; mf = 0;
  endtask

  task automatic model_step(input logic c, input logic [7:0] s, input logic a);
    bit [7:0] q;
    int low;
    if (c) begin
      model_reset();
      return;
    end
    for (int i = 0; i < NZONES; i++) q[i] = (run[i] >= DEBOUNCE);
    case (ph)
      P_IDLE: if (q != 0) begin
        low = 0;
        while (!q[low]) low++;
        mz = low; mr = 0; mwait = 0; ph = P_REQ;
      end
      P_REQ: if (a) ph = P_SWEEP;
      else begin
        mwait++;
`ifdef FIRE_DET_FAULT_EN
        if (mwait >= ACK_TIMEOUT) ph = P_FAULT;
`endif
      end
      P_SWEEP: if (!a) ph = P_CHECK;
      P_CHECK: if (!q[mz]) begin
        ph = P_IDLE; mf = (mf + 1) % 256;
      end else begin
`ifdef FIRE_DET_FAULT_EN
        if (mr == MAX_RETRY) ph = P_FAULT;
        else begin mr++; mwait = 0; ph = P_REQ; end
`else
        mr++; mwait = 0; ph = P_REQ;
`endif
      end
      default: ;
    endcase
    for (int i = 0; i < NZONES; i++) run[i] = s[i] ? ((run[i] < 1000) ? run[i] + 1 : run[i]) : 0;
  endtask

  task automatic cycle(input logic c, input logic [7:0] s, input logic a);
    clr = c; sensor = s; ext_active = a;
    @(posedge clk);
    model_step(c, s, a);
    #1;
    check("enable", int'(enable), int'(ph == P_REQ));
    check("alarm", int'(alarm), int'(ph != P_IDLE));
    check("fault", int'(fault), int'(ph == P_FAULT));
    check("zone", int'(zone), mz);
    check("fires_handled", int'(fires_handled), mf);
  endtask

  // Behavioural extinguisher: answers REQ after a short delay, sweeps a few
  // cycles, and optionally puts the fire out as the sweep ends (mode 0 never,
  // 1 always, 2 randomly).
  logic       ext_q;
  logic [7:0] sens_q;
  int         ext_len, ext_dly;

  task automatic auto_reset();
    ext_q = 1'b0; ext_len = 0; ext_dly = 0;
  endtask

  task automatic auto_cycle(input bit rnd_sensors, input int clear_mode);
    if (ext_q) begin
      ext_len--;
      if (ext_len <= 0) begin
        ext_q = 1'b0;
        if (clear_mode == 1 || (clear_mode == 2 && $urandom_range(9) < 7)) sens_q[mz] = 1'b0;
      end
    end else if (ph == P_REQ) begin
      if (ext_dly == 0) begin
        ext_q   = 1'b1;
        ext_len = $urandom_range(6, 1);
        ext_dly = $urandom_range(3);
      end else begin
        ext_dly--;
      end
    end
    if (rnd_sensors)
      for (int i = 0; i < NZONES; i++) if ($urandom_range(11) == 0) sens_q[i] = ~sens_q[i];
    cycle(1'b0, sens_q, ext_q);
  endtask

  initial begin
    bit found;
    model_reset();
    auto_reset();

    // Reset state
    cycle(1'b1, 8'h00, 1'b0);
    check("reset_enable", int'(enable), 0);
    check("reset_fires", int'(fires_handled), 0);

    // Short glitch on zone 3 never qualifies
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h08, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b0);
    check("glitch_alarm", int'(alarm), 0);

    // Zone 3 held: enable rises on the 5th edge, then a clean sweep
    cycle(1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h08, 1'b0);
    check("z3_enable_edge4", int'(enable), 0);
    cycle(1'b0, 8'h08, 1'b0);
    check("z3_enable_edge5", int'(enable), 1);
    check("z3_zone_edge5", int'(zone), 3);
    for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b0);
    check("z3_fires", int'(fires_handled), 1);
    check("z3_idle_zone", int'(zone), 3);

    // Zones 1 and 6 together: 1 first, then 6
    cycle(1'b1, 8'h00, 1'b0);
    auto_reset();
    sens_q = 8'h42;
    for (int i = 0; i < 5; i++) auto_cycle(1'b0, 1);
    check("pri_first_zone", int'(zone), 1);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      auto_cycle(1'b0, 1);
      if (ph == P_REQ && mz == 6) found = 1'b1;
    end
    check("pri_second_reached", int'(found), 1);
    check("pri_second_zone", int'(zone), 6);

    // Zone 0 never goes out: retries, then FAULT when the limit applies
    cycle(1'b1, 8'h00, 1'b0);
    auto_reset();
    sens_q = 8'h01;
    for (int i = 0; i < 80; i++) auto_cycle(1'b0, 0);
`ifdef FIRE_DET_FAULT_EN
    check("retry_fault", int'(fault), 1);
    check("retry_enable", int'(enable), 0);
`endif
    check("retry_alarm", int'(alarm), 1);

    // No acknowledge from the extinguisher
    cycle(1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h10, 1'b0);
    check("ack_req_entry", int'(enable), 1);
    for (int i = 0; i < ACK_TIMEOUT - 1; i++) cycle(1'b0, 8'h10, 1'b0);
    check("ack_before_timeout", int'(enable), 1);
    cycle(1'b0, 8'h10, 1'b0);
`ifdef FIRE_DET_FAULT_EN
    check("ack_timeout_fault", int'(fault), 1);
`else
    for (int i = 0; i < 70; i++) cycle(1'b0, 8'h10, 1'b0);
    check("ack_wait_forever", int'(enable), 1);
`endif

    // clr during SWEEP, then requalification from a zero count
    cycle(1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h04, 1'b0);
    cycle(1'b0, 8'h04, 1'b1);
    cycle(1'b0, 8'h04, 1'b1);
    cycle(1'b1, 8'h04, 1'b1);
    check("clr_alarm", int'(alarm), 0);
    check("clr_zone", int'(zone), 0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h04, 1'b0);
    check("requal_edge4", int'(enable), 0);
    cycle(1'b0, 8'h04, 1'b0);
    check("requal_edge5", int'(enable), 1);

    // Counter wrap: 257 quick fires on zone 7
    cycle(1'b1, 8'h00, 1'b0);
    for (int n = 0; n < 257; n++) begin
      for (int i = 0; i < 10 && ph != P_REQ; i++) cycle(1'b0, 8'h80, 1'b0);
      cycle(1'b0, 8'h00, 1'b1);
      cycle(1'b0, 8'h00, 1'b0);
      cycle(1'b0, 8'h00, 1'b0);
    end
    check("wrap_fires", int'(fires_handled), 1);

    // Randomized traffic with occasional clr
    cycle(1'b1, 8'h00, 1'b0);
    auto_reset();
    sens_q = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(399) == 0) begin
        auto_reset();
        cycle(1'b1, sens_q, 1'b0);
      end else begin
        auto_cycle(1'b1, 2);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
